softmax_argmax_decoder: RTL and testbench
=========================================

Name: softmax_argmax_decoder

Overview:
- Consumer at the far end of the softmax layer's output vector: accepts one N-entry vector of signed fixed-point probabilities and sequentially scans it.
- Reports the winning class index and its probability through a valid/ready handshake.
- Sits between the RNN softmax stage and the classification result interface; serial scan, one element per clock.

Parameters:
- N, 10, number of classes (vector length), N >= 1
- WIDTH, 16, width of each probability word (signed)
- NFRAC, 10, fractional bits of each word (pass-through only; compare is raw signed)
- IDX_W, $clog2(N) (min 1), width of the class index output
- MARGIN_THRESH, 16'sh0100, low-confidence threshold in WIDTH/NFRAC format (0.25); used only with the optional feature

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- dataIn  input  WIDTH x [N-1:0]  signed probability vector from softmax
- in_valid  input  1  dataIn is valid
- in_ready  output  1  block can accept a vector
- class_idx  output  IDX_W  index of the maximum element
- max_val  output  WIDTH  signed value of the maximum element
- out_valid  output  1  class_idx/max_val valid
- out_ready  input  1  downstream accepts the result
- margin  output  WIDTH  max minus second-largest (MARGIN_EN only)
- low_conf  output  1  margin < MARGIN_THRESH (MARGIN_EN only)

Behaviour:
- Reset (reset==0, async): state=IDLE, counter=0, class_idx=0, max_val=0, out_valid=0, margin=0, low_conf=0; captured vector cleared to 0. Release is synchronous to clk in effect: the first active edge after release sees IDLE.
- in_ready = (state==IDLE), registered-state decode only; no combinational path from out_ready.
- FSM states IDLE, SCAN, DONE.
- IDLE: on edge with in_valid && in_ready, capture all N words into an internal vector register; best=word[0], best_idx=0, cnt=1. Go to SCAN, or to DONE if N==1.
- SCAN: each edge compares word[cnt] to best using a signed compare.
  - Replace best/best_idx only if strictly greater; ties keep the lower index.
  - If cnt==N-1, go to DONE and set out_valid=1; otherwise cnt++.
- Latency: out_valid rises N-1 edges after the accepting edge (same edge when N==1).
- DONE: class_idx/max_val/out_valid held stable while out_ready==0. On edge with out_ready==1, clear out_valid and go to IDLE.
- class_idx and max_val keep their last values after the handshake.
- Throughput: one vector per N+1 cycles minimum (accept, N-1 scan, handshake); in_valid ignored outside IDLE.
- dataIn may change after acceptance without effect; only the captured copy is scanned.
- Negative entries (softmax cap disabled) are compared correctly as signed; an all-negative vector returns the least negative.
- Reset mid-SCAN or mid-DONE aborts immediately; the partial result is discarded and no out_valid is produced.

Optional Feature:
- Macro SOFTMAX_ARGMAX_MARGIN_EN.
- Defined:
  - A second register tracks the second-largest value (init to most-negative WIDTH value at accept). On replace, old best moves to second; else if word > second, second=word. A tie with best sets second=best.
  - At DONE entry: margin = best - second, saturated to the WIDTH signed range; low_conf = (margin < MARGIN_THRESH).
  - N==1: margin = max positive, low_conf=0.
- Undefined: margin/low_conf ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset during SCAN: N=4, accept, drive reset=0 at cycle 2 -> out_valid=0, in_ready=1 after release, class_idx=0, no result emitted.
- Basic: N=4, dataIn={0x0100,0x0200,0x0080,0x0080} (index 0..3) -> out_valid 3 edges after accept, class_idx=1, max_val=0x0200; margin=0x0100, low_conf=0.
- Tie and backpressure: dataIn={0x0100,0x0100,0x0100,0x0100}, out_ready=0 for 5 cycles -> class_idx=0 held stable with out_valid=1 throughout; in_ready=0; margin=0, low_conf=1.
- Negative entries: dataIn={-16'sh0400,-16'sh0010,-16'sh0200,-16'sh7fff} -> class_idx=1, max_val=0xFFF0.
- Back-to-back: two vectors with winners at index 3 (0x0300) then index 2 (0x03FF), in_valid held high, out_ready=1 -> second accept occurs the edge after the first handshake; results 3/0x0300 then 2/0x03FF; dataIn changes during SCAN ignored.
- N=1 config: dataIn={0x0123} -> out_valid on the accept edge, class_idx=0, max_val=0x0123; margin=0x7FFF, low_conf=0.

Source files
------------

// File: rtl/softmax_argmax_decoder.sv
// softmax_argmax_decoder: captures one N-entry signed probability vector and
// scans it serially, one element per clock, reporting the arg-max index and
// value through a valid/ready handshake. Ties keep the lower index.
// Optional margin / low-confidence outputs: define SOFTMAX_ARGMAX_MARGIN_EN.
module softmax_argmax_decoder #(
    parameter int N     = 10,
    parameter int WIDTH = 16,
    parameter int NFRAC = 10,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
    parameter logic [WIDTH-1:0] MARGIN_THRESH = 16'sh0100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0][WIDTH-1:0]   dataIn,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [IDX_W-1:0]          class_idx,
    output logic [WIDTH-1:0]          max_val,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
    ,
    output logic [WIDTH-1:0]          margin,
    output logic                      low_conf
`endif
);

    // Elaboration-time sanity on the configuration.
    if (N < 1) begin : g_bad_n
        $error("softmax_argmax_decoder: N must be >= 1");
    end
    if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_nfrac
        $error("softmax_argmax_decoder: NFRAC out of range");
    end
    if (MARGIN_THRESH[WIDTH-1]) begin : g_bad_thresh
        $error("softmax_argmax_decoder: MARGIN_THRESH must be non-negative");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t                     state_q, state_d;
    logic [N-1:0][WIDTH-1:0]    vec_q, vec_d;
    logic [IDX_W-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0]    best_q, best_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic [IDX_W-1:0]           class_idx_q, class_idx_d;
    logic [WIDTH-1:0]           max_val_q, max_val_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0]    word;

`ifdef SOFTMAX_ARGMAX_MARGIN_EN
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    logic signed [WIDTH-1:0]    second_q, second_d;
    logic [WIDTH-1:0]           margin_q, margin_d;
    logic                       low_conf_q, low_conf_d;
    logic signed [WIDTH:0]      diff;
`endif

    // Next-state logic: accept, serial compare, result handshake.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        out_valid_d = out_valid_q;
        word        = vec_q[cnt_q];
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        second_d    = second_q;
        margin_d    = margin_q;
        low_conf_d  = low_conf_q;
        diff        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d      = dataIn;
                    best_d     = dataIn[0];
                    best_idx_d = '0;
                    cnt_d      = IDX_W'(1);
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
                    second_d   = S_MIN;
`endif
                    if (N == 1) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        class_idx_d = '0;
                        max_val_d   = dataIn[0];
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
                        margin_d    = S_MAX;
                        low_conf_d  = 1'b0;
`endif
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (word > best_q) begin
                    best_d     = word;
                    best_idx_d = cnt_q;
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
                    second_d   = best_q;
`endif
                end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
                else if (word == best_q) begin
                    second_d = best_q;
                end else if (word > second_q) begin
                    second_d = word;
                end
`endif
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    class_idx_d = best_idx_d;
                    max_val_d   = best_d;
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
                    // best >= second, so only positive overflow can occur.
                    diff = {best_d[WIDTH-1], best_d} - {second_d[WIDTH-1], second_d};
                    if (diff[WIDTH] != diff[WIDTH-1]) begin
                        margin_d = S_MAX;
                    end else begin
                        margin_d = diff[WIDTH-1:0];
                    end
                    low_conf_d = $signed(margin_d) < $signed(MARGIN_THRESH);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; async reset aborts any scan in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
            second_q    <= '0;
            margin_q    <= '0;
            low_conf_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
            out_valid_q <= out_valid_d;
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
            second_q    <= second_d;
            margin_q    <= margin_d;
            low_conf_q  <= low_conf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;
    assign out_valid = out_valid_q;
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
    assign margin    = margin_q;
    assign low_conf  = low_conf_q;
`endif

endmodule

// File: tb/tb_softmax_argmax_decoder.sv
// Directed testbench for softmax_argmax_decoder: an N=4 instance for the main
// scenarios and an N=1 instance for the degenerate single-class case.
module tb_softmax_argmax_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic [3:0][15:0] d4_in;
    logic             d4_iv, d4_ir, d4_ov, d4_or;
    logic [1:0]       d4_idx;
    logic [15:0]      d4_max;
    // N=1 instance
    logic [0:0][15:0] d1_in;
    logic             d1_iv, d1_ir, d1_ov, d1_or;
    logic [0:0]       d1_idx;
    logic [15:0]      d1_max;
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
    logic [15:0]      d4_margin, d1_margin;
    logic             d4_lc, d1_lc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    softmax_argmax_decoder #(.N(4), .WIDTH(16), .NFRAC(10)) dut4 (
        .clk(clk), .reset(reset), .dataIn(d4_in), .in_valid(d4_iv),
        .in_ready(d4_ir), .class_idx(d4_idx), .max_val(d4_max),
        .out_valid(d4_ov), .out_ready(d4_or)
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        , .margin(d4_margin), .low_conf(d4_lc)
`endif
    );

    softmax_argmax_decoder #(.N(1), .WIDTH(16), .NFRAC(10)) dut1 (
        .clk(clk), .reset(reset), .dataIn(d1_in), .in_valid(d1_iv),
        .in_ready(d1_ir), .class_idx(d1_idx), .max_val(d1_max),
        .out_valid(d1_ov), .out_ready(d1_or)
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        , .margin(d1_margin), .low_conf(d1_lc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector for one edge on the N=4 instance.
    task automatic send4(input logic [3:0][15:0] v);
        d4_in = v;
        d4_iv = 1'b1;
        tick();
        d4_iv = 1'b0;
    endtask

    // Edges until out_valid rises on the N=4 instance; 99 if it never does.
    task automatic wait_valid4(output int k);
        k = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (d4_ov === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_cmp++; if (d4_ov !== 1'b0) begin n_bad++; $display("FAIL rst_ov4 got=%b exp=0", d4_ov); end
        n_cmp++; if (d4_ir !== 1'b1) begin n_bad++; $display("FAIL rst_ir4 got=%b exp=1", d4_ir); end
        n_cmp++; if (d4_idx !== 2'd0) begin n_bad++; $display("FAIL rst_idx4 got=%0d exp=0", d4_idx); end
        n_cmp++; if (d4_max !== 16'h0000) begin n_bad++; $display("FAIL rst_max4 got=%h exp=0000", d4_max); end
        n_cmp++; if (d1_ov !== 1'b0) begin n_bad++; $display("FAIL rst_ov1 got=%b exp=0", d1_ov); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d4_margin !== 16'h0000) begin n_bad++; $display("FAIL rst_margin got=%h exp=0000", d4_margin); end
        n_cmp++; if (d4_lc !== 1'b0) begin n_bad++; $display("FAIL rst_lowconf got=%b exp=0", d4_lc); end
`endif
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        d4_or = 1'b1;
        send4({16'h0400, 16'h0300, 16'h0200, 16'h0100});
        n_cmp++; if (d4_ir !== 1'b0) begin n_bad++; $display("FAIL rms_busy got=%b exp=0", d4_ir); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (d4_ov !== 1'b0) begin n_bad++; $display("FAIL rms_ov got=%b exp=0", d4_ov); end
        n_cmp++; if (d4_ir !== 1'b1) begin n_bad++; $display("FAIL rms_ir got=%b exp=1", d4_ir); end
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (d4_ov === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rms_no_result got=%0d valid cycles exp=0", seen); end
        n_cmp++; if (d4_idx !== 2'd0) begin n_bad++; $display("FAIL rms_idx got=%0d exp=0", d4_idx); end
        n_cmp++; if (d4_ir !== 1'b1) begin n_bad++; $display("FAIL rms_ir_after got=%b exp=1", d4_ir); end
    endtask

    task automatic test_basic();
        int k;
        d4_or = 1'b1;
        send4({16'h0080, 16'h0080, 16'h0200, 16'h0100});
        wait_valid4(k);
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL basic_latency got=%0d exp=3", k); end
        n_cmp++; if (d4_idx !== 2'd1) begin n_bad++; $display("FAIL basic_idx got=%0d exp=1", d4_idx); end
        n_cmp++; if (d4_max !== 16'h0200) begin n_bad++; $display("FAIL basic_max got=%h exp=0200", d4_max); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d4_margin !== 16'h0100) begin n_bad++; $display("FAIL basic_margin got=%h exp=0100", d4_margin); end
        n_cmp++; if (d4_lc !== 1'b0) begin n_bad++; $display("FAIL basic_lowconf got=%b exp=0", d4_lc); end
`endif
        tick();
        n_cmp++; if (d4_ov !== 1'b0) begin n_bad++; $display("FAIL basic_hs_ov got=%b exp=0", d4_ov); end
        n_cmp++; if (d4_ir !== 1'b1) begin n_bad++; $display("FAIL basic_hs_ir got=%b exp=1", d4_ir); end
        n_cmp++; if (d4_idx !== 2'd1) begin n_bad++; $display("FAIL basic_hold_idx got=%0d exp=1", d4_idx); end
    endtask

    task automatic test_tie_backpressure();
        int k;
        d4_or = 1'b0;
        send4({16'h0100, 16'h0100, 16'h0100, 16'h0100});
        wait_valid4(k);
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL tie_latency got=%0d exp=3", k); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d4_margin !== 16'h0000) begin n_bad++; $display("FAIL tie_margin got=%h exp=0000", d4_margin); end
        n_cmp++; if (d4_lc !== 1'b1) begin n_bad++; $display("FAIL tie_lowconf got=%b exp=1", d4_lc); end
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (d4_ov !== 1'b1) begin n_bad++; $display("FAIL tie_hold_ov[%0d] got=%b exp=1", i, d4_ov); end
            n_cmp++; if (d4_idx !== 2'd0) begin n_bad++; $display("FAIL tie_hold_idx[%0d] got=%0d exp=0", i, d4_idx); end
            n_cmp++; if (d4_ir !== 1'b0) begin n_bad++; $display("FAIL tie_hold_ir[%0d] got=%b exp=0", i, d4_ir); end
        end
        n_cmp++; if (d4_max !== 16'h0100) begin n_bad++; $display("FAIL tie_max got=%h exp=0100", d4_max); end
        d4_or = 1'b1;
        tick();
        n_cmp++; if (d4_ov !== 1'b0) begin n_bad++; $display("FAIL tie_release got=%b exp=0", d4_ov); end
    endtask

    task automatic test_negative();
        int k;
        d4_or = 1'b1;
        send4({16'h8001, 16'hFE00, 16'hFFF0, 16'hFC00});
        wait_valid4(k);
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL neg_latency got=%0d exp=3", k); end
        n_cmp++; if (d4_idx !== 2'd1) begin n_bad++; $display("FAIL neg_idx got=%0d exp=1", d4_idx); end
        n_cmp++; if (d4_max !== 16'hFFF0) begin n_bad++; $display("FAIL neg_max got=%h exp=fff0", d4_max); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d4_margin !== 16'h01F0) begin n_bad++; $display("FAIL neg_margin got=%h exp=01f0", d4_margin); end
        n_cmp++; if (d4_lc !== 1'b0) begin n_bad++; $display("FAIL neg_lowconf got=%b exp=0", d4_lc); end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        d4_or = 1'b1;
        d4_in = {16'h0300, 16'h0100, 16'h0200, 16'h0050};
        d4_iv = 1'b1;
        tick();
        // second vector presented during the scan of the first
        d4_in = {16'h0001, 16'h03FF, 16'h0300, 16'h0000};
        wait_valid4(k);
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL b2b_lat_a got=%0d exp=3", k); end
        n_cmp++; if (d4_idx !== 2'd3) begin n_bad++; $display("FAIL b2b_idx_a got=%0d exp=3", d4_idx); end
        n_cmp++; if (d4_max !== 16'h0300) begin n_bad++; $display("FAIL b2b_max_a got=%h exp=0300", d4_max); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d4_margin !== 16'h0100) begin n_bad++; $display("FAIL b2b_margin_a got=%h exp=0100", d4_margin); end
        n_cmp++; if (d4_lc !== 1'b0) begin n_bad++; $display("FAIL b2b_lc_a got=%b exp=0", d4_lc); end
`endif
        tick();
        n_cmp++; if (d4_ir !== 1'b1) begin n_bad++; $display("FAIL b2b_hs_ir got=%b exp=1", d4_ir); end
        tick();
        n_cmp++; if (d4_ir !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_b got=%b exp=0", d4_ir); end
        d4_iv = 1'b0;
        wait_valid4(k);
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL b2b_lat_b got=%0d exp=3", k); end
        n_cmp++; if (d4_idx !== 2'd2) begin n_bad++; $display("FAIL b2b_idx_b got=%0d exp=2", d4_idx); end
        n_cmp++; if (d4_max !== 16'h03FF) begin n_bad++; $display("FAIL b2b_max_b got=%h exp=03ff", d4_max); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d4_margin !== 16'h00FF) begin n_bad++; $display("FAIL b2b_margin_b got=%h exp=00ff", d4_margin); end
        n_cmp++; if (d4_lc !== 1'b1) begin n_bad++; $display("FAIL b2b_lc_b got=%b exp=1", d4_lc); end
`endif
        tick();
    endtask

    task automatic test_single_class();
        d1_or = 1'b1;
        d1_in = 16'h0123;
        d1_iv = 1'b1;
        tick();
        d1_iv = 1'b0;
        n_cmp++; if (d1_ov !== 1'b1) begin n_bad++; $display("FAIL n1_ov got=%b exp=1", d1_ov); end
        n_cmp++; if (d1_idx !== 1'b0) begin n_bad++; $display("FAIL n1_idx got=%0d exp=0", d1_idx); end
        n_cmp++; if (d1_max !== 16'h0123) begin n_bad++; $display("FAIL n1_max got=%h exp=0123", d1_max); end
        n_cmp++; if (d1_ir !== 1'b0) begin n_bad++; $display("FAIL n1_ir got=%b exp=0", d1_ir); end
`ifdef SOFTMAX_ARGMAX_MARGIN_EN
        n_cmp++; if (d1_margin !== 16'h7FFF) begin n_bad++; $display("FAIL n1_margin got=%h exp=7fff", d1_margin); end
        n_cmp++; if (d1_lc !== 1'b0) begin n_bad++; $display("FAIL n1_lowconf got=%b exp=0", d1_lc); end
`endif
        tick();
        n_cmp++; if (d1_ov !== 1'b0) begin n_bad++; $display("FAIL n1_release got=%b exp=0", d1_ov); end
        n_cmp++; if (d1_ir !== 1'b1) begin n_bad++; $display("FAIL n1_ir_after got=%b exp=1", d1_ir); end
    endtask

    initial begin
        d4_in = '0; d4_iv = 1'b0; d4_or = 1'b0;
        d1_in = '0; d1_iv = 1'b0; d1_or = 1'b0;
        test_reset();
        test_reset_mid_scan();
        test_basic();
        test_tie_backpressure();
        test_negative();
        test_back_to_back();
        test_single_class();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
